// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator car model: state encoding, direction
// codes and the floor-code width used by the car and its controller.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        ARRIVE = 2'd2,
        FAULT  = 2'd3
    } state_e;

    localparam logic DIR_UP  = 1'b1;
    localparam logic DIR_DN  = 1'b0;
    localparam int   FLOOR_W = 3;

    // One floor step in the given direction; limits are checked before a move
    // starts, so this never wraps in practice.
    function automatic logic [FLOOR_W-1:0] step_floor(input logic [FLOOR_W-1:0] f,
                                                      input logic               d);
        logic [FLOOR_W-1:0] one;
        one = {{(FLOOR_W-1){1'b0}}, 1'b1};
        return (d == DIR_UP) ? f + one : f - one;
    endfunction

endpackage

// File: rtl/car_motion_floor_timer.sv
// Per-floor travel timer: loads TICKS-1 while cleared, counts down while
// enabled and flags done on the last cycle of a floor's travel time.
module floor_timer #(
    parameter int TICKS = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic done_o
);

    localparam int            CW   = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TICKS - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= LOAD;
        end else if (clear_i) begin
            cnt_q <= LOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign done_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/car_motion.sv
// Plant-side elevator car: executes one-floor moves requested by the
// controller, paces travel, enforces door interlock and floor limits.
//
//  state  | meaning
//  IDLE   | parked at a floor, waiting for an accepted go
//  MOVE   | travelling one floor, timer running
//  ARRIVE | one-cycle arrival pulse after the floor update
//  FAULT  | door opened while moving; frozen until reset
module car_motion
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = 8,
    parameter int FLOOR_TICKS = 50,
    parameter int RESET_FLOOR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic               dir,
    input  logic               door,
    output logic [FLOOR_W-1:0] floor,
    output logic               moving,
    output logic               arrive,
    output logic               at_top,
    output logic               at_bottom,
    output logic               fault
);

    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W-1:0] RST_FLOOR = FLOOR_W'(RESET_FLOOR);

    state_e             state_q;
    logic [FLOOR_W-1:0] floor_q;
    logic [FLOOR_W-1:0] floor_d;
    logic               dir_q;
    logic               moving_q;
    logic               arrive_q;
    logic               fault_q;

    logic               top_w;
    logic               bottom_w;
    logic               limit_hit;
    logic               start_move;
    logic               tmr_done;

    assign top_w      = (floor_q == TOP_FLOOR);
    assign bottom_w   = (floor_q == '0);
    assign limit_hit  = (dir == DIR_UP) ? top_w : bottom_w;
    assign start_move = go && !door && !limit_hit;
    assign floor_d    = step_floor(floor_q, dir_q);

    floor_timer #(
        .TICKS (FLOOR_TICKS)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear_i (state_q == IDLE),
        .en_i    (state_q == MOVE),
        .done_o  (tmr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            floor_q  <= RST_FLOOR;
            dir_q    <= DIR_DN;
            moving_q <= 1'b0;
            arrive_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    arrive_q <= 1'b0;
                    if (start_move) begin
                        state_q  <= MOVE;
                        dir_q    <= dir;
                        moving_q <= 1'b1;
                    end
                end
                MOVE: begin
                    // Door takes priority over the terminal tick: no floor update.
                    if (door) begin
                        state_q  <= FAULT;
                        moving_q <= 1'b0;
                        fault_q  <= 1'b1;
                    end else if (tmr_done) begin
                        state_q  <= ARRIVE;
                        floor_q  <= floor_d;
                        moving_q <= 1'b0;
                        arrive_q <= 1'b1;
                    end
                end
                ARRIVE: begin
                    state_q  <= IDLE;
                    arrive_q <= 1'b0;
                end
                FAULT: begin
                    moving_q <= 1'b0;
                    arrive_q <= 1'b0;
                    fault_q  <= 1'b1;
                end
            endcase
        end
    end

    assign floor     = floor_q;
    assign moving    = moving_q;
    assign arrive    = arrive_q;
    assign at_top    = top_w;
    assign at_bottom = bottom_w;
    assign fault     = fault_q;

endmodule

// File: tb/tb_car_motion.sv
// Bench for car_motion: directed scenarios plus random traffic, all outputs
// compared every cycle against a timestamp-based model of the car.
module tb_car_motion;

    localparam int FT = 50;
    localparam int NF = 8;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       go   = 1'b0;
    logic       dir  = 1'b0;
    logic       door = 1'b0;
    logic [2:0] floor;
    logic       moving, arrive, at_top, at_bottom, fault;

    car_motion #(
        .NUM_FLOORS  (NF),
        .FLOOR_TICKS (FT),
        .RESET_FLOOR (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .dir       (dir),
        .door      (door),
        .floor     (floor),
        .moving    (moving),
        .arrive    (arrive),
        .at_top    (at_top),
        .at_bottom (at_bottom),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: edge index k; a move accepted at edge s lands at edge s+FT,
    // and the car may accept again from edge s+FT+2.
    int k       = 0;
    int m_floor = 0;
    bit m_moving = 1'b0;
    bit m_fault  = 1'b0;
    int m_start  = 0;
    int m_dir    = 0;
    int m_arr    = -1;
    int m_ok     = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_floor  = 0;
            m_moving = 1'b0;
            m_fault  = 1'b0;
            m_arr    = -1;
            m_ok     = 0;
        end else begin
            k = k + 1;
            if (!m_fault) begin
                if (m_moving) begin
                    if (door) begin
                        m_fault  = 1'b1;
                        m_moving = 1'b0;
                    end else if (k == m_start + FT) begin
                        m_floor  = m_floor + (m_dir ? 1 : -1);
                        m_moving = 1'b0;
                        m_arr    = k;
                    end
                end else if (k >= m_ok && go && !door &&
                             !(dir ? (m_floor == NF - 1) : (m_floor == 0))) begin
                    m_moving = 1'b1;
                    m_start  = k;
                    m_dir    = dir ? 1 : 0;
                    m_ok     = k + FT + 2;
                end
            end
        end
    end

    int ncyc = 0;
    int arr_times[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    task automatic compare_loop();
        logic [2:0] ef;
        logic [4:0] got, exp;
        forever begin
            @(negedge clk);
            ncyc++;
            if (arrive) arr_times.push_back(ncyc);
            ef  = 3'(m_floor);
            got = {moving, arrive, at_top, at_bottom, fault};
            exp = {m_moving, (m_arr == k), (m_floor == NF - 1), (m_floor == 0), m_fault};
            tests++;
            if (floor !== ef || got !== exp) begin
                fails++;
                $display("FAIL model_cmp cycle %0d: got floor=%0d mv/ar/top/bot/flt=%b, expected floor=%0d mv/ar/top/bot/flt=%b",
                         ncyc, floor, got, ef, exp);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        go   = 1'b0;
        door = 1'b0;
        dir  = 1'b0;
        cyc(3);
        rst = 1'b0;
    endtask

    initial begin
        int n0;
        fork
            compare_loop();
        join_none

        // Reset state
        cyc(3);
        check("rst_floor", floor, 0);
        check("rst_bottom", at_bottom, 1);
        check("rst_top", at_top, 0);
        check("rst_moving", moving, 0);
        check("rst_fault", fault, 0);
        rst = 1'b0;

        // Single one-floor move up
        n0 = arr_times.size();
        go = 1'b1; dir = 1'b1;
        cyc(1);
        go = 1'b0;
        check("t2_moving_start", moving, 1);
        cyc(49);
        check("t2_moving_last", moving, 1);
        check("t2_floor_before", floor, 0);
        cyc(1);
        check("t2_floor_after", floor, 1);
        check("t2_arrive", arrive, 1);
        check("t2_moving_end", moving, 0);
        check("t2_model_floor", m_floor, 1);
        cyc(1);
        check("t2_arrive_single", arrive, 0);
        check("t2_arrive_count", arr_times.size() - n0, 1);

        // Reset mid-move
        go = 1'b1; dir = 1'b1;
        cyc(1);
        go = 1'b0;
        cyc(25);
        check("rst_mid_moving_pre", moving, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_floor", floor, 0);
        check("rst_mid_moving", moving, 0);
        check("rst_mid_bottom", at_bottom, 1);
        check("rst_mid_fault", fault, 0);
        cyc(2);
        rst = 1'b0;

        // Held go: climb 0 -> 7
        n0 = arr_times.size();
        go = 1'b1; dir = 1'b1;
        cyc(7 * 52 + 20);
        check("t3_arrive_count", arr_times.size() - n0, 7);
        for (int i = n0 + 1; i < arr_times.size(); i++)
            check("t3_arrive_gap", arr_times[i] - arr_times[i-1], 52);
        check("t3_floor", floor, 7);
        check("t3_top", at_top, 1);
        cyc(60);
        check("t3_floor_hold", floor, 7);
        check("t3_moving_hold", moving, 0);

        // Full descent with dir toggled during each move
        for (int i = 0; i < 7 * 52 + 20; i++) begin
            dir = m_moving ? 1'($urandom_range(0, 1)) : 1'b0;
            cyc(1);
        end
        check("t6_floor", floor, 0);
        check("t6_bottom", at_bottom, 1);
        check("t6_model_floor", m_floor, 0);

        // Refused requests at the bottom
        go = 1'b1; dir = 1'b0;
        cyc(10);
        check("t4_down_moving", moving, 0);
        check("t4_down_floor", floor, 0);
        dir = 1'b1; door = 1'b1;
        cyc(10);
        check("t4_door_moving", moving, 0);
        check("t4_door_fault", fault, 0);
        go = 1'b0; door = 1'b0;
        cyc(1);

        // Door opened mid-move at tick 20
        go = 1'b1; dir = 1'b1;
        cyc(1);
        go = 1'b0;
        cyc(20);
        door = 1'b1;
        cyc(1);
        check("t5_fault", fault, 1);
        check("t5_moving", moving, 0);
        check("t5_floor", floor, 0);
        door = 1'b0;
        go = 1'b1;
        cyc(100);
        check("t5_floor_frozen", floor, 0);
        check("t5_fault_sticky", fault, 1);
        go = 1'b0;
        do_reset();
        check("t5_fault_cleared", fault, 0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ((m_fault && $urandom_range(0, 19) == 0) || $urandom_range(0, 1499) == 0) begin
                do_reset();
            end else begin
                go   = ($urandom_range(0, 3) != 0);
                dir  = 1'($urandom_range(0, 1));
                door = ($urandom_range(0, 149) == 0);
                cyc(1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
